// File: rtl/pipelined_mux_tree.sv
// pipelined_mux_tree: SEL_W-level binary mux tree, one register stage per level,
// with a single global advance so every stage stalls together under backpressure.
module pipelined_mux_tree #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [(2**SEL_W)*WIDTH-1:0]     in_data,
    input  logic [SEL_W-1:0]                in_sel,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [SEL_W-1:0]                out_sel,
    output logic                            out_valid,
    input  logic                            out_ready
);
    localparam int N = 2**SEL_W;
    // Registered nodes: stage s occupies N>>s entries at offset N - 2*(N>>s); root is last.
    logic [WIDTH-1:0] node [N-1];
    // Source view for each level: input lanes followed by every non-root node.
    logic [WIDTH-1:0] src [2*N-2];
    logic [SEL_W-1:0] sel_q [1:SEL_W];
    logic             vld_q [1:SEL_W];
    logic [SEL_W-1:0] sel_src [0:SEL_W-1];
    logic             vld_src [0:SEL_W-1];
    logic             adv;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_data  = node[N-2];
    assign out_sel   = sel_q[SEL_W];
    assign out_valid = vld_q[SEL_W];

    always_comb begin
        for (int k = 0; k < N; k++) src[k] = in_data[k*WIDTH +: WIDTH];
        for (int k = N; k < 2*N-2; k++) src[k] = node[k-N];
        sel_src[0] = in_sel;
        vld_src[0] = in_valid;
        for (int s = 1; s < SEL_W; s++) begin
            sel_src[s] = sel_q[s];
            vld_src[s] = vld_q[s];
        end
    end

    // Data and select only load behind a real beat, so outputs hold across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N-1; k++) node[k] <= '0;
            for (int s = 1; s <= SEL_W; s++) begin
                sel_q[s] <= '0;
                vld_q[s] <= 1'b0;
            end
        end else if (adv) begin
            for (int s = 1; s <= SEL_W; s++) begin
                vld_q[s] <= vld_src[s-1];
                if (vld_src[s-1]) begin
                    sel_q[s] <= sel_src[s-1];
                    for (int m = 0; m < (N >> s); m++)
                        node[N - 2*(N >> s) + m] <= sel_src[s-1][s-1] ? src[2*N - 4*(N >> s) + 2*m + 1]
                                                                      : src[2*N - 4*(N >> s) + 2*m];
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_mux_tree.sv
// tb_pipelined_mux_tree: directed and randomized checks against a queue-based reference.
module tb_pipelined_mux_tree;
    localparam int W = 8;
    localparam int S = 2;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*W-1:0]   in_data;
    logic [S-1:0]     in_sel;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]     out_data;
    logic [S-1:0]     out_sel;

    logic [31:0]      b_in_data;
    logic             b_in_sel, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sel;
    logic [15:0]      b_out_data;

    pipelined_mux_tree #(.WIDTH(W), .SEL_W(S)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    pipelined_mux_tree #(.WIDTH(16), .SEL_W(1)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_sel(b_out_sel), .out_valid(b_out_valid),
        .out_ready(b_out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic [S-1:0] s;
        int           t;
    } beat_t;

    beat_t        q[$];
    int           total = 0, bad = 0, cyc_n = 0, nout = 0, sent;
    logic         lat_chk = 1'b0;
    logic         ir_s, ov_s;
    logic [W-1:0] od_s, pod = '0;
    logic [S-1:0] os_s, pos = '0;
    logic         pov = 1'b0, prdy = 1'b1, prst = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, observe, update the reference queue.
    task automatic cyc(input logic v, input logic [S-1:0] s, input logic r, input logic rs = 1'b0);
        beat_t e;
        in_valid = v; in_sel = s; out_ready = r; rst = rs;
        #1;
        ir_s = in_ready; ov_s = out_valid; od_s = out_data; os_s = out_sel;
        if (rs) q.delete();
        else begin
            chk("in_ready", {31'b0, ir_s}, {31'b0, !ov_s || r});
            if (pov && !prdy && !prst) begin
                chk("hold_data", {24'b0, od_s}, {24'b0, pod});
                chk("hold_sel", {30'b0, os_s}, {30'b0, pos});
            end
            if (ov_s && r) begin
                nout++;
                if (q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    chk("out_data", {24'b0, od_s}, {24'b0, e.d});
                    chk("out_sel", {30'b0, os_s}, {30'b0, e.s});
                    if (lat_chk) chk("latency", cyc_n - e.t, S);
                end
            end
            if (v && ir_s) begin
                e.d = in_data[s*W +: W]; e.s = s; e.t = cyc_n;
                q.push_back(e);
            end
        end
        pov = ov_s; prdy = r; prst = rs; pod = od_s; pos = os_s;
        cyc_n++;
        @(negedge clk);
    endtask

    initial begin
        in_data = 32'h44332211;
        b_in_data = {16'h5555, 16'hAAAA}; b_in_sel = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        @(negedge clk);
        cyc(1'b0, 2'd0, 1'b1, 1'b1);
        cyc(1'b1, 2'd3, 1'b1, 1'b1);
        cyc(1'b0, 2'd0, 1'b1);
        chk("rst_valid", {31'b0, ov_s}, 32'd0);
        chk("rst_data", {24'b0, od_s}, 32'd0);
        chk("rst_sel", {30'b0, os_s}, 32'd0);
        chk("rst_ready", {31'b0, ir_s}, 32'd1);
        chk("rst_b_valid", {31'b0, b_out_valid}, 32'd0);

        // single beat, latency two
        cyc(1'b1, 2'd2, 1'b1);
        cyc(1'b0, 2'd0, 1'b1);
        chk("single_early", {31'b0, ov_s}, 32'd0);
        cyc(1'b0, 2'd0, 1'b1);
        chk("single_valid", {31'b0, ov_s}, 32'd1);
        chk("single_data", {24'b0, od_s}, 32'h33);
        chk("single_sel", {30'b0, os_s}, 32'd2);
        cyc(1'b0, 2'd0, 1'b1);
        chk("single_after", {31'b0, ov_s}, 32'd0);
        chk("idle_hold", {24'b0, od_s}, 32'h33);

        // back-to-back beats
        for (int i = 0; i < 6; i++) begin
            cyc(i < 4, 2'(i), 1'b1);
            if (i >= 2) begin
                chk("b2b_valid", {31'b0, ov_s}, 32'd1);
                chk("b2b_data", {24'b0, od_s}, 32'h11 * (i - 1));
            end
        end
        cyc(1'b0, 2'd0, 1'b1);
        cyc(1'b0, 2'd0, 1'b1);

        // stall for three cycles after the first output
        sent = 0; nout = 0;
        for (int k = 0; k < 20; k++) begin
            logic v;
            v = sent < 4;
            cyc(v, 2'(sent), !(k >= 2 && k <= 4));
            if (k >= 2 && k <= 4) begin
                chk("stall_ready", {31'b0, ir_s}, 32'd0);
                chk("stall_data", {24'b0, od_s}, 32'h11);
            end
            if (v && ir_s) sent++;
        end
        chk("stall_count", nout, 4);

        // alternating valid
        for (int k = 0; k < 8; k++) begin
            cyc(k < 4 && k % 2 == 0, 2'(k), 1'b1);
            if (k >= 2 && k <= 5) chk("alt_valid", {31'b0, ov_s}, {31'b0, k % 2 == 0});
        end

        // reset with beats in flight; the beat during reset must not be accepted
        nout = 0;
        cyc(1'b1, 2'd0, 1'b1);
        cyc(1'b1, 2'd1, 1'b1);
        cyc(1'b1, 2'd2, 1'b0, 1'b1);
        cyc(1'b0, 2'd0, 1'b1);
        chk("mid_rst_valid", {31'b0, ov_s}, 32'd0);
        chk("mid_rst_data", {24'b0, od_s}, 32'd0);
        chk("mid_rst_sel", {30'b0, os_s}, 32'd0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 2'd0, 1'b1);
        chk("mid_rst_leak", nout, 0);

        // WIDTH=16, SEL_W=1 instance
        b_in_sel = 1'b1; b_in_valid = 1'b1;
        cyc(1'b0, 2'd0, 1'b1);
        chk("b_valid", {31'b0, b_out_valid}, 32'd1);
        chk("b_data1", {16'b0, b_out_data}, 32'h5555);
        chk("b_sel1", {31'b0, b_out_sel}, 32'd1);
        b_in_sel = 1'b0;
        cyc(1'b0, 2'd0, 1'b1);
        chk("b_data0", {16'b0, b_out_data}, 32'hAAAA);
        chk("b_sel0", {31'b0, b_out_sel}, 32'd0);
        b_in_valid = 1'b0;
        cyc(1'b0, 2'd0, 1'b1);
        chk("b_idle", {31'b0, b_out_valid}, 32'd0);

        // random traffic, no backpressure: exact latency
        lat_chk = 1'b1;
        for (int k = 0; k < 300; k++) begin
            in_data = $urandom;
            cyc($urandom_range(0, 3) != 0, 2'($urandom), 1'b1);
        end
        lat_chk = 1'b0;

        // random traffic with backpressure and occasional reset
        for (int k = 0; k < 600; k++) begin
            in_data = $urandom;
            cyc($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 99) == 0);
        end
        for (int k = 0; k < 8; k++) cyc(1'b0, 2'd0, 1'b1);
        chk("drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
